// File: rtl/pixel_stream_gen_pkg.sv
// Shared types and constants for the synthetic pixel stream source.
// Contents: coordinate/data/counter widths, FSM state enum, pattern mode
// enum, Bayer colour enum with its site lookup, and the channel values
// used by the test patterns.
package pixel_stream_pkg;

    localparam int unsigned COORD_W = 11;
    localparam int unsigned DATA_W  = 12;
    localparam int unsigned FCNT_W  = 16;
    localparam int unsigned MODE_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } state_t;

    typedef enum logic [MODE_W-1:0] {
        MODE_RAMP    = 2'd0,
        MODE_BAYER   = 2'd1,
        MODE_CHECKER = 2'd2,
        MODE_CONST   = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        BAYER_G = 2'd0,
        BAYER_R = 2'd1,
        BAYER_B = 2'd2
    } bayer_t;

    // Flat-field channel levels for the Bayer pattern.
    localparam logic [DATA_W-1:0] CHAN_R = 12'hFFF;
    localparam logic [DATA_W-1:0] CHAN_G = 12'h800;
    localparam logic [DATA_W-1:0] CHAN_B = 12'h000;

    // Checkerboard levels.
    localparam logic [DATA_W-1:0] CHECK_HI = 12'hFFF;
    localparam logic [DATA_W-1:0] CHECK_LO = 12'h000;

    // GRBG tiling: even rows are G R, odd rows are B G.
    function automatic bayer_t bayer_colour(input logic y0, input logic x0);
        bayer_t col;
        unique case ({y0, x0})
            2'b00:   col = BAYER_G;
            2'b01:   col = BAYER_R;
            2'b10:   col = BAYER_B;
            default: col = BAYER_G;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/pixel_stream_gen_if.sv
// Control and pixel-stream bundle between the pattern source and its host
// and consumer.
// Control (host -> source): start, stop, mode, const_val.
// Stream  (source -> consumer): x_cont, y_cont, data, dval, frame_start,
// frame_cnt, busy.
// master = pixel source, slave = host/consumer side.
interface pixel_stream_gen_if;
    import pixel_stream_pkg::*;

    logic                start;
    logic                stop;
    logic [MODE_W-1:0]   mode;
    logic [DATA_W-1:0]   const_val;

    logic [COORD_W-1:0]  x_cont;
    logic [COORD_W-1:0]  y_cont;
    logic [DATA_W-1:0]   data;
    logic                dval;
    logic                frame_start;
    logic [FCNT_W-1:0]   frame_cnt;
    logic                busy;

    modport master (
        input  start, stop, mode, const_val,
        output x_cont, y_cont, data, dval, frame_start, frame_cnt, busy
    );

    modport slave (
        output start, stop, mode, const_val,
        input  x_cont, y_cont, data, dval, frame_start, frame_cnt, busy
    );

endinterface

// File: rtl/pixel_stream_gen_pattern.sv
// Combinational test-pattern generator: (mode, x, y, const) -> pixel value.
// Ports: mode (pattern select), x/y (pixel coordinate), const_val (value
// for constant mode), data_c (unregistered pixel value).
module pixel_pattern
    import pixel_stream_pkg::*;
(
    input  mode_t               mode,
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    input  logic [DATA_W-1:0]   const_val,
    output logic [DATA_W-1:0]   data_c
);

    // Pattern select.
    always_comb begin
        data_c = '0;
        unique case (mode)
            MODE_RAMP: begin
                // 12-bit add wraps naturally at 4096.
                data_c = DATA_W'(x) + DATA_W'(y);
            end
            MODE_BAYER: begin
                unique case (bayer_colour(y[0], x[0]))
                    BAYER_R: data_c = CHAN_R;
                    BAYER_B: data_c = CHAN_B;
                    default: data_c = CHAN_G;
                endcase
            end
            MODE_CHECKER: begin
                // 16x16 tiles.
                data_c = (x[4] ^ y[4]) ? CHECK_HI : CHECK_LO;
            end
            default: begin
                data_c = const_val;
            end
        endcase
    end

endmodule

// File: rtl/pixel_stream_gen.sv
// Synthetic camera-side pixel source: raster frames with line and frame
// blanking, selectable test pattern, frame start pulse and frame counter.
// Ports: clk (pixel clock), rst (async active-high reset),
// stream (pixel_stream_gen_if.master: control in, registered stream out).
// All stream outputs are registered one cycle behind the internal
// counters, so pixel (0,0) appears two edges after start is sampled.
module pixel_stream_gen
    import pixel_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 1280,
    parameter int unsigned V_ACTIVE    = 960,
    parameter int unsigned H_BLANK     = 32,
    parameter int unsigned V_BLANK_CYC = 256
) (
    input  logic                clk,
    input  logic                rst,
    pixel_stream_gen_if.master  stream
);

    localparam int unsigned BLANK_MAX = (H_BLANK > V_BLANK_CYC) ? H_BLANK : V_BLANK_CYC;
    localparam int unsigned BLANK_W   = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

    localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(V_ACTIVE - 1);
    localparam logic [BLANK_W-1:0] HB_LAST = BLANK_W'(H_BLANK - 1);
    localparam logic [BLANK_W-1:0] VB_LAST = BLANK_W'(V_BLANK_CYC - 1);

    state_t              state_q, state_d;
    logic [COORD_W-1:0]  x_q, x_d;
    logic [COORD_W-1:0]  y_q, y_d;
    logic [BLANK_W-1:0]  cnt_q, cnt_d;
    logic                stop_req_q, stop_req_d;
    mode_t               mode_q, mode_d;
    logic [DATA_W-1:0]   const_q, const_d;

    logic [COORD_W-1:0]  x_out_d;
    logic [COORD_W-1:0]  y_out_d;
    logic [DATA_W-1:0]   data_d;
    logic                dval_d;
    logic                frame_start_d;
    logic [FCNT_W-1:0]   frame_cnt_d;
    logic                busy_d;

    logic [DATA_W-1:0]   pattern_c;

    pixel_pattern u_pattern (
        .mode      (mode_q),
        .x         (x_q),
        .y         (y_q),
        .const_val (const_q),
        .data_c    (pattern_c)
    );

    // State, counters and registered stream outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q            <= ST_IDLE;
            x_q                <= '0;
            y_q                <= '0;
            cnt_q              <= '0;
            stop_req_q         <= 1'b0;
            mode_q             <= MODE_RAMP;
            const_q            <= '0;
            stream.x_cont      <= '0;
            stream.y_cont      <= '0;
            stream.data        <= '0;
            stream.dval        <= 1'b0;
            stream.frame_start <= 1'b0;
            stream.frame_cnt   <= '0;
            stream.busy        <= 1'b0;
        end else begin
            state_q            <= state_d;
            x_q                <= x_d;
            y_q                <= y_d;
            cnt_q              <= cnt_d;
            stop_req_q         <= stop_req_d;
            mode_q             <= mode_d;
            const_q            <= const_d;
            stream.x_cont      <= x_out_d;
            stream.y_cont      <= y_out_d;
            stream.data        <= data_d;
            stream.dval        <= dval_d;
            stream.frame_start <= frame_start_d;
            stream.frame_cnt   <= frame_cnt_d;
            stream.busy        <= busy_d;
        end
    end

    // Next-state, counter and output logic.
    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        cnt_d         = cnt_q;
        stop_req_d    = stop_req_q;
        mode_d        = mode_q;
        const_d       = const_q;
        x_out_d       = stream.x_cont;
        y_out_d       = stream.y_cont;
        data_d        = '0;
        dval_d        = 1'b0;
        frame_start_d = 1'b0;
        frame_cnt_d   = stream.frame_cnt;
        busy_d        = (state_q != ST_IDLE);

        if (state_q != ST_IDLE && stream.stop) begin
            stop_req_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (stream.start) begin
                    state_d    = ST_ACTIVE;
                    x_d        = '0;
                    y_d        = '0;
                    // start+stop together requests exactly one frame
                    stop_req_d = stream.stop;
                    mode_d     = mode_t'(stream.mode);
                    const_d    = stream.const_val;
                end
            end

            ST_ACTIVE: begin
                dval_d  = 1'b1;
                data_d  = pattern_c;
                x_out_d = x_q;
                y_out_d = y_q;
                if (x_q == '0 && y_q == '0) begin
                    frame_start_d = 1'b1;
                    frame_cnt_d   = stream.frame_cnt + FCNT_W'(1);
                end
                if (x_q == X_LAST) begin
                    state_d = ST_HBLANK;
                    cnt_d   = '0;
                end else begin
                    x_d = x_q + COORD_W'(1);
                end
            end

            ST_HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    if (y_q < Y_LAST) begin
                        state_d = ST_ACTIVE;
                        x_d     = '0;
                        y_d     = y_q + COORD_W'(1);
                    end else begin
                        state_d = ST_VBLANK;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + BLANK_W'(1);
                end
            end

            ST_VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    // a stop arriving on the final blank cycle still ends the run
                    if (stop_req_q || stream.stop) begin
                        state_d    = ST_IDLE;
                        stop_req_d = 1'b0;
                    end else begin
                        state_d = ST_ACTIVE;
                        x_d     = '0;
                        y_d     = '0;
                        mode_d  = mode_t'(stream.mode);
                        const_d = stream.const_val;
                    end
                end else begin
                    cnt_d = cnt_q + BLANK_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
